// File: rtl/fetch_mem_unit_if.sv
// Request/ready bus between fetch_mem_unit (master) and an 8-bit memory (slave).
interface fetch_mem_unit_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/fetch_mem_unit.sv
// PC/IR/TR/MDR owner that turns controller level strobes into one memory
// transaction at a time, tolerating wait states and flagging a timeout.
module fetch_mem_unit #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              IorD,
    input  logic              IRld,
    input  logic              TRld,
    input  logic              MDRld,
    input  logic              pcWrite,
    input  logic              jmpSignal,
    input  logic [7:0]        wr_data,
    fetch_mem_unit_if.master  bus,
    output logic [7:0]        ins,
    output logic [7:0]        tr,
    output logic [7:0]        mdr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    typedef struct packed {
        logic ir;
        logic mdr;
        logic pcw;
        logic jmp;
    } pend_t;

    state_t            state;
    pend_t             pend;
    logic [7:0]        rdl;
    logic [7:0]        cnt;
    logic              start;
    logic              done;
    logic              rd_done;
    logic              expire;
    logic [7:0]        rdl_nxt;
    logic [12:0]       jmp_raw;
    logic [ADDR_W-1:0] pc_jmp;
    logic [ADDR_W-1:0] pc_inc;

    assign start   = (state == IDLE) && (memRead || memWrite);
    assign done    = (state == WAIT) && bus.mem_ready;
    assign rd_done = done && !bus.mem_we;
    assign expire  = (state == WAIT) && !bus.mem_ready && (cnt == 8'(TIMEOUT - 1));

    // Read data bypasses RDL so a same-cycle TRld or jump sees the new byte.
    assign rdl_nxt = rd_done ? bus.mem_rdata : rdl;
    assign jmp_raw = {ins[4:0], rdl_nxt};
    assign pc_jmp  = ADDR_W'(jmp_raw);
    assign pc_inc  = pc + ADDR_W'(1);

    assign busy = start || ((state == WAIT) && !bus.mem_ready) || (state == ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pend          <= '0;
            pc            <= '0;
            ins           <= '0;
            tr            <= '0;
            mdr           <= '0;
            rdl           <= '0;
            cnt           <= '0;
            err           <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            if (TRld)
                tr <= rdl_nxt;
            if (rd_done)
                rdl <= bus.mem_rdata;

            case (state)
                IDLE: begin
                    if (start) begin
                        bus.mem_addr  <= IorD ? ADDR_W'(tr) : pc;
                        bus.mem_wdata <= wr_data;
                        bus.mem_we    <= memWrite;
                        bus.mem_req   <= 1'b1;
                        pend          <= '{ir: IRld, mdr: MDRld, pcw: pcWrite, jmp: jmpSignal};
                        cnt           <= '0;
                        state         <= WAIT;
                    end else if (pcWrite) begin
                        pc <= jmpSignal ? pc_jmp : pc_inc;
                    end
                end
                WAIT: begin
                    if (bus.mem_ready) begin
                        if (pend.ir)
                            ins <= bus.mem_rdata;
                        if (pend.mdr)
                            mdr <= bus.mem_rdata;
                        if (pend.pcw)
                            pc <= pend.jmp ? pc_jmp : pc_inc;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= IDLE;
                    end else if (expire) begin
                        // Abort: nothing from this access is committed.
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        err         <= 1'b1;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_mem_unit.sv
// Bench for fetch_mem_unit: directed vector table, corner sequences and
// randomized traffic checked against a transaction-level model.
module tb_fetch_mem_unit;
    localparam int TMO = 15;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic       iord;
        logic       irld;
        logic       trld;
        logic       mdrld;
        logic       pcw;
        logic       jmp;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       rdy;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       busy;
        logic       req;
        logic       we;
        logic [7:0] addr;
        logic [7:0] pc;
        logic [7:0] ins;
        logic [7:0] tr;
        logic [7:0] mdr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       memRead = 0, memWrite = 0, IorD = 0, IRld = 0, TRld = 0;
    logic       MDRld = 0, pcWrite = 0, jmpSignal = 0;
    logic [7:0] wr_data = '0;
    logic [7:0] ins, tr, mdr, pc;
    logic       busy, err;

    fetch_mem_unit_if #(.ADDR_W(8)) bus ();

    fetch_mem_unit #(.ADDR_W(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .memRead(memRead), .memWrite(memWrite), .IorD(IorD), .IRld(IRld),
        .TRld(TRld), .MDRld(MDRld), .pcWrite(pcWrite), .jmpSignal(jmpSignal),
        .wr_data(wr_data), .bus(bus),
        .ins(ins), .tr(tr), .mdr(mdr), .pc(pc), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int   checks = 0;
    int   failures = 0;
    logic busy_seen;

    // Transaction-level reference: registers plus the one access in flight.
    logic [7:0] m_pc, m_ins, m_tr, m_mdr, m_rdl;
    bit         m_err, m_acc, m_dead;
    logic [7:0] a_addr, a_wdata;
    bit         a_we, a_ir, a_mdr, a_pcw, a_jmp;
    int         a_waits;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t st(input bit rd, wr, iord, irld, trld, mdrld, pcw, jmp,
                                 input logic [7:0] wdata, rdata, input bit rdy);
        stim_t s;
        s = '{rd, wr, iord, irld, trld, mdrld, pcw, jmp, wdata, rdata, rdy};
        return s;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ins = 0; m_tr = 0; m_mdr = 0; m_rdl = 0;
        m_err = 0; m_acc = 0; m_dead = 0; a_waits = 0;
        a_addr = 0; a_wdata = 0; a_we = 0;
    endtask

    function automatic logic [7:0] next_pc(input bit jmp, input logic [7:0] rdl);
        logic [12:0] t;
        t = {m_ins[4:0], rdl};
        return jmp ? t[7:0] : m_pc + 8'd1;
    endfunction

    function automatic bit exp_busy(input stim_t s);
        return m_dead || (m_acc && !s.rdy) || (!m_acc && !m_dead && (s.rd || s.wr));
    endfunction

    task automatic model_clk(input stim_t s);
        logic [7:0] nrdl, nins, tr_old;
        nrdl = m_rdl; nins = m_ins; tr_old = m_tr;
        if (m_acc && s.rdy && !a_we) nrdl = s.rdata;
        if (s.trld) m_tr = nrdl;
        if (m_dead) begin
            m_dead = 1;
        end else if (m_acc) begin
            if (s.rdy) begin
                if (a_ir) nins = s.rdata;
                if (a_mdr) m_mdr = s.rdata;
                if (a_pcw) m_pc = next_pc(a_jmp, nrdl);
                m_acc = 0;
            end else begin
                a_waits++;
                if (a_waits >= TMO) begin
                    m_dead = 1; m_acc = 0; m_err = 1;
                end
            end
        end else if (s.rd || s.wr) begin
            m_acc = 1; a_waits = 0;
            a_addr = s.iord ? tr_old : m_pc;
            a_wdata = s.wdata; a_we = s.wr;
            a_ir = s.irld; a_mdr = s.mdrld; a_pcw = s.pcw; a_jmp = s.jmp;
        end else if (s.pcw) begin
            m_pc = next_pc(s.jmp, m_rdl);
        end
        m_rdl = nrdl;
        m_ins = nins;
    endtask

    task automatic drive(input stim_t s);
        memRead = s.rd; memWrite = s.wr; IorD = s.iord; IRld = s.irld;
        TRld = s.trld; MDRld = s.mdrld; pcWrite = s.pcw; jmpSignal = s.jmp;
        wr_data = s.wdata; bus.mem_rdata = s.rdata; bus.mem_ready = s.rdy;
    endtask

    task automatic cyc(input stim_t s);
        @(negedge clk);
        drive(s);
        #1;
        busy_seen = busy;
        chk("busy", busy, exp_busy(s));
        @(posedge clk);
        model_clk(s);
        #1;
        chk("pc", pc, m_pc);
        chk("ins", ins, m_ins);
        chk("tr", tr, m_tr);
        chk("mdr", mdr, m_mdr);
        chk("err", err, m_err);
        chk("mem_req", bus.mem_req, m_acc);
        if (m_acc) begin
            chk("mem_addr", bus.mem_addr, a_addr);
            chk("mem_wdata", bus.mem_wdata, a_wdata);
            chk("mem_we", bus.mem_we, a_we);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        drive('0);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_ins"}, ins, 0);
        chk({tag, "_tr"}, tr, 0);
        chk({tag, "_mdr"}, mdr, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_req"}, bus.mem_req, 0);
        chk({tag, "_we"}, bus.mem_we, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t tbl[15];

    initial begin
        stim_t idle;
        idle = '0;
        //          rd wr io ir tr md pw jp wdata  rdata  rdy   busy req we addr  pc     ins    tr     mdr
        tbl[0]  = '{st(1,0,0,1,0,0,1,0, 8'h00, 8'h00, 0), 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{st(0,0,0,0,0,0,0,0, 8'h00, 8'hA5, 1), 0, 0, 0, 8'h00, 8'h01, 8'hA5, 8'h00, 8'h00};
        tbl[2]  = '{st(0,0,0,0,0,0,0,0, 8'h00, 8'h00, 0), 0, 0, 0, 8'h00, 8'h01, 8'hA5, 8'h00, 8'h00};
        tbl[3]  = '{st(1,0,0,1,0,0,1,0, 8'h00, 8'h00, 0), 1, 1, 0, 8'h01, 8'h01, 8'hA5, 8'h00, 8'h00};
        tbl[4]  = '{st(0,0,0,0,0,0,0,0, 8'h00, 8'hC0, 1), 0, 0, 0, 8'h00, 8'h02, 8'hC0, 8'h00, 8'h00};
        tbl[5]  = '{st(1,0,0,0,0,1,0,0, 8'h00, 8'h00, 0), 1, 1, 0, 8'h02, 8'h02, 8'hC0, 8'h00, 8'h00};
        tbl[6]  = '{st(0,0,0,0,0,0,0,0, 8'h00, 8'h7E, 1), 0, 0, 0, 8'h00, 8'h02, 8'hC0, 8'h00, 8'h7E};
        tbl[7]  = '{st(0,0,0,0,1,0,1,1, 8'h00, 8'h00, 0), 0, 0, 0, 8'h00, 8'h7E, 8'hC0, 8'h7E, 8'h7E};
        tbl[8]  = '{st(1,0,0,0,0,0,0,0, 8'h00, 8'h00, 0), 1, 1, 0, 8'h7E, 8'h7E, 8'hC0, 8'h7E, 8'h7E};
        tbl[9]  = '{st(0,0,0,0,1,0,0,0, 8'h00, 8'h3C, 1), 0, 0, 0, 8'h00, 8'h7E, 8'hC0, 8'h3C, 8'h7E};
        tbl[10] = '{st(0,1,1,0,0,0,0,0, 8'h5A, 8'h00, 0), 1, 1, 1, 8'h3C, 8'h7E, 8'hC0, 8'h3C, 8'h7E};
        tbl[11] = '{st(0,0,0,0,0,0,0,0, 8'h00, 8'h00, 0), 1, 1, 1, 8'h3C, 8'h7E, 8'hC0, 8'h3C, 8'h7E};
        tbl[12] = '{st(1,0,0,1,0,1,1,0, 8'h11, 8'h22, 0), 1, 1, 1, 8'h3C, 8'h7E, 8'hC0, 8'h3C, 8'h7E};
        tbl[13] = '{st(0,0,0,0,0,0,0,0, 8'h00, 8'h00, 0), 1, 1, 1, 8'h3C, 8'h7E, 8'hC0, 8'h3C, 8'h7E};
        tbl[14] = '{st(0,0,0,0,0,0,0,0, 8'h00, 8'hFF, 1), 0, 0, 0, 8'h00, 8'h7E, 8'hC0, 8'h3C, 8'h7E};

        drive(idle);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc, 0);
        chk("reset_ins", ins, 0);
        chk("reset_err", err, 0);
        chk("reset_req", bus.mem_req, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table: zero-wait fetch, jump via RDL, TR bypass, 3-wait store.
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].s);
            chk($sformatf("tbl%0d_busy", i), busy_seen, tbl[i].busy);
            chk($sformatf("tbl%0d_req", i), bus.mem_req, tbl[i].req);
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("tbl%0d_ins", i), ins, tbl[i].ins);
            chk($sformatf("tbl%0d_tr", i), tr, tbl[i].tr);
            chk($sformatf("tbl%0d_mdr", i), mdr, tbl[i].mdr);
            if (tbl[i].req) begin
                chk($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].addr);
                chk($sformatf("tbl%0d_we", i), bus.mem_we, tbl[i].we);
                if (tbl[i].we) chk($sformatf("tbl%0d_wdata", i), bus.mem_wdata, 8'h5A);
            end
        end

        // PC wrap: jump to 0xFF, then an incrementing fetch.
        cyc(st(1,0,0,0,0,0,0,0, 8'h00, 8'h00, 0));
        cyc(st(0,0,0,0,0,0,0,0, 8'h00, 8'hFF, 1));
        cyc(st(0,0,0,0,0,0,1,1, 8'h00, 8'h00, 0));
        chk("wrap_pc_ff", pc, 8'hFF);
        cyc(st(1,0,0,1,0,0,1,0, 8'h00, 8'h00, 0));
        chk("wrap_addr", bus.mem_addr, 8'hFF);
        cyc(st(0,0,0,0,0,0,0,0, 8'h00, 8'h12, 1));
        chk("wrap_pc_00", pc, 8'h00);
        chk("wrap_ins", ins, 8'h12);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            stim_t s;
            int r;
            r = $urandom_range(0, 99);
            s = '0;
            s.rd    = (r < 30) || (r >= 40 && r < 43);
            s.wr    = (r >= 30 && r < 43);
            s.iord  = 1'($urandom_range(0, 1));
            s.irld  = ($urandom_range(0, 3) == 0);
            s.mdrld = ($urandom_range(0, 3) == 0);
            s.trld  = ($urandom_range(0, 4) == 0);
            s.pcw   = ($urandom_range(0, 2) == 0);
            s.jmp   = ($urandom_range(0, 2) == 0);
            s.wdata = 8'($urandom);
            s.rdata = 8'($urandom);
            s.rdy   = ($urandom_range(0, 9) < 6);
            cyc(s);
        end

        pulse_reset("rst_a");
        cyc(st(1,0,0,1,0,0,1,0, 8'h00, 8'h00, 0));
        cyc(st(0,0,0,0,0,0,0,0, 8'h00, 8'h3B, 1));
        chk("pre_to_pc", pc, 8'h01);
        chk("pre_to_ins", ins, 8'h3B);

        // Timeout: 15 WAIT cycles with no ready, then sticky error.
        cyc(st(1,0,0,1,0,0,1,0, 8'h00, 8'h00, 0));
        for (int i = 1; i <= TMO; i++) begin
            cyc(st(0,0,0,0,0,0,0,0, 8'h00, 8'($urandom), 0));
            chk("to_busy", busy_seen, 1);
            if (i == TMO - 1) begin
                chk("to_err_early", err, 0);
                chk("to_req_early", bus.mem_req, 1);
            end
        end
        chk("to_err", err, 1);
        chk("to_req", bus.mem_req, 0);
        chk("to_pc", pc, 8'h01);
        chk("to_ins", ins, 8'h3B);
        for (int i = 0; i < 3; i++) begin
            cyc(st(1,0,0,1,0,0,1,0, 8'h00, 8'h55, 1));
            chk("err_busy", busy_seen, 1);
            chk("err_hold", err, 1);
            chk("err_pc", pc, 8'h01);
            chk("err_req", bus.mem_req, 0);
        end

        // Recovery: reset clears the error, then abandon an access mid-WAIT.
        pulse_reset("rst_err");
        cyc(st(1,0,0,1,0,0,1,0, 8'h00, 8'h00, 0));
        cyc(st(0,0,0,0,0,0,0,0, 8'h00, 8'h44, 1));
        chk("rec_pc", pc, 8'h01);
        cyc(st(1,0,0,1,0,0,1,0, 8'h00, 8'h00, 0));
        cyc(st(0,0,0,0,0,0,0,0, 8'h00, 8'h00, 0));
        chk("rec_req", bus.mem_req, 1);
        pulse_reset("rst_wait");
        cyc(st(0,0,0,0,0,0,0,0, 8'h00, 8'h99, 1));
        chk("post_rst_ins", ins, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_mem_unit.md
Name: fetch_mem_unit

Overview:
- Sits between the multicycle controller and the 8-bit memory; owns PC, IR, TR, MDR and the memory request handshake.
- Turns the controller's level strobes (memRead, memWrite, IorD, IRld, TRld, MDRld, pcWrite, jmpSignal) into a request/ready transaction.
- Drives ins back to the controller.
- Adds wait-state tolerance, a stall output, and a timeout error so slow memories can be attached.

Parameters:
- ADDR_W, 8, width of PC, TR-based address and mem_addr.
- TIMEOUT, 15, maximum wait cycles per access before abort (1..255).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- memRead  in  1  controller read strobe.
- memWrite  in  1  controller write strobe.
- IorD  in  1  address select: 0=PC, 1=TR.
- IRld  in  1  load IR from the read completing this cycle.
- TRld  in  1  load TR from read-data latch RDL.
- MDRld  in  1  load MDR from the read completing this cycle.
- pcWrite  in  1  PC update request.
- jmpSignal  in  1  PC update selects jump target instead of increment.
- wr_data  in  8  store data from register file.
- mem_rdata  in  8  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes current access this cycle.
- mem_req  out  1  access in progress.
- mem_we  out  1  1=write access.
- mem_addr  out  ADDR_W  latched access address.
- mem_wdata  out  8  latched store data.
- ins  out  8  IR contents, to controller.
- tr  out  8  TR contents.
- mdr  out  8  MDR contents.
- pc  out  ADDR_W  current PC.
- busy  out  1  stall: access pending and not completing this cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - pc, ins, tr, mdr, RDL, mem_addr, mem_wdata all 0.
  - mem_req=0, mem_we=0, err=0, wait counter=0.
- State machine: IDLE, WAIT, ERR.
- IDLE:
  - If memRead|memWrite: latch mem_addr = IorD ? tr[ADDR_W-1:0] : pc; mem_wdata=wr_data; mem_we=memWrite (memWrite wins if both asserted).
  - Latch the pending load set {IRld, MDRld, pcWrite, jmpSignal}.
  - Go to WAIT with mem_req=1 from the next cycle; counter=0.
  - Otherwise stay in IDLE; a pcWrite with no memory strobe applies immediately.
- WAIT:
  - mem_req=1; busy = ~mem_ready.
  - On mem_ready: RDL <= mem_rdata (reads only).
  - On mem_ready, IR <= mem_rdata if latched IRld; MDR <= mem_rdata if latched MDRld.
  - On mem_ready, latched pcWrite is applied.
  - Then mem_req <= 0 and return to IDLE.
  - busy is also 1 in the IDLE cycle in which a request is accepted, so the controller holds its state until completion.
- PC update:
  - Increment: pc+1, mod 2^ADDR_W; wraps from all-ones to 0.
  - Jump (jmpSignal=1): target = {ins[4:0], RDL} truncated to ADDR_W LSBs. RDL is bypassed, so a jump issued in the same cycle RDL is written uses the new byte.
- TRld: tr <= RDL in any state, independent of memory strobes. Same-cycle TRld and RDL write loads the new value.
- Timeout:
  - Counter increments each WAIT cycle without mem_ready.
  - When it reaches TIMEOUT: go to ERR, drop mem_req; err=1; no register loads; PC unchanged.
  - ERR holds busy=1 until reset. Only reset clears err.
- Strobes asserted during WAIT are ignored; no queueing.
- mem_ready while in IDLE is ignored.
- Reset mid-transaction: access abandoned, all outputs return to reset values immediately.
- mem_addr and mem_wdata stay stable for the whole access, even if PC/TR change.

Test Plan:
- Fetch, zero-wait: pc=0x00, memRead+IRld+pcWrite, mem_ready asserted first WAIT cycle with mem_rdata=0xA5 -> mem_addr=0x00, ins=0xA5, pc=0x01, busy high exactly 1 cycle.
- Three wait states: store memWrite, IorD=1, tr=0x3C, wr_data=0x5A, mem_ready after 3 cycles -> mem_we=1, mem_addr=0x3C, mem_wdata=0x5A held all 4 WAIT cycles; busy=1 for 4 cycles; no IR/MDR change.
- Jump: ins=0xC0, read returns 0x7E, then TRld+jmpSignal+pcWrite -> tr=0x7E, pc=0x7E.
- PC wrap: pc=0xFF, increment fetch -> pc=0x00.
- Timeout: TIMEOUT=15, mem_ready held low -> after 15 WAIT cycles err=1, mem_req=0, pc/ins unchanged, busy stays 1.
- Recovery: pulse rst low mid-WAIT -> err=0, pc=0, mem_req=0.
